// File: rtl/cache_addr_decode_flush_if.sv
// Lookup/flush/invalidate bus between the memory-stage address path and the cache tag array.
// The slave side is the decoder/flush sequencer; the master side is the requester plus the tag array.
interface cache_addr_decode_flush_if #(
    parameter int ADDR_W     = 32,
    parameter int NUM_SETS   = 16,
    parameter int LINE_BYTES = 4,
    parameter int NUM_WAYS   = 2
);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int OFF_PW   = (OFFSET_W > 0) ? OFFSET_W : 1;

    logic [ADDR_W-1:0]  address;
    logic               addr_valid;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [OFF_PW-1:0]  offset;
    logic               dec_valid;
    logic               flush_req;
    logic               flush_all;
    logic [ADDR_W-1:0]  flush_address;
    logic               flush_busy;
    logic               flush_done;
    logic               inv_valid;
    logic [INDEX_W-1:0] inv_index;
    logic [WAY_W-1:0]   inv_way;
    logic               inv_ready;

    modport master (
        output address, addr_valid, flush_req, flush_all, flush_address, inv_ready,
        input  tag, index, offset, dec_valid, flush_busy, flush_done, inv_valid, inv_index, inv_way
    );

    modport slave (
        input  address, addr_valid, flush_req, flush_all, flush_address, inv_ready,
        output tag, index, offset, dec_valid, flush_busy, flush_done, inv_valid, inv_index, inv_way
    );
endinterface

// File: rtl/cache_addr_decode_flush.sv
// Data-cache address decoder (one register stage) plus a flush engine that walks
// one set or the whole cache, issuing one invalidate per accepted handshake.
module cache_addr_decode_flush #(
    parameter int ADDR_W     = 32,
    parameter int NUM_SETS   = 16,
    parameter int LINE_BYTES = 4,
    parameter int NUM_WAYS   = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    cache_addr_decode_flush_if.slave bus
);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int OFF_PW   = (OFFSET_W > 0) ? OFFSET_W : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WAY_W-1:0]   WAY_LAST = WAY_W'(NUM_WAYS - 1);
    localparam logic [INDEX_W-1:0] SET_LAST = INDEX_W'(NUM_SETS - 1);

    logic [1:0]         state, state_nx;
    logic [INDEX_W-1:0] idx, idx_nx, last, last_nx;
    logic [WAY_W-1:0]   way, way_nx;
    logic [INDEX_W-1:0] flush_set;
    logic [OFF_PW-1:0]  off_nx;

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [OFF_PW-1:0]  offset_q;
    logic               dec_valid_q;

    assign flush_set = bus.flush_address[OFFSET_W +: INDEX_W];
    // With single-byte lines there is no offset field; the port stays 1 bit tied low.
    assign off_nx    = (OFFSET_W > 0) ? bus.address[OFF_PW-1:0] : '0;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        way_nx   = way;
        last_nx  = last;
        case (state)
            S_IDLE: begin
                if (bus.flush_req) begin
                    state_nx = S_INV;
                    idx_nx   = bus.flush_all ? '0 : flush_set;
                    last_nx  = bus.flush_all ? SET_LAST : flush_set;
                    way_nx   = '0;
                end
            end
            S_INV: begin
                if (bus.inv_ready) begin
                    if (way == WAY_LAST) begin
                        if (idx == last) begin
                            state_nx = S_DONE;
                        end else begin
                            idx_nx = idx + 1'b1;
                            way_nx = '0;
                        end
                    end else begin
                        way_nx = way + 1'b1;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            way   <= '0;
            last  <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            way   <= way_nx;
            last  <= last_nx;
        end
    end

    // Lookups only qualify when the machine lands in IDLE, so an accepted flush drops them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            index_q     <= '0;
            offset_q    <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            tag_q       <= bus.address[ADDR_W-1 -: TAG_W];
            index_q     <= bus.address[OFFSET_W +: INDEX_W];
            offset_q    <= off_nx;
            dec_valid_q <= bus.addr_valid & (state_nx == S_IDLE);
        end
    end

    assign bus.tag        = tag_q;
    assign bus.index      = index_q;
    assign bus.offset     = offset_q;
    assign bus.dec_valid  = dec_valid_q;
    assign bus.inv_valid  = (state == S_INV);
    assign bus.inv_index  = (state == S_INV) ? idx : '0;
    assign bus.inv_way    = (state == S_INV) ? way : '0;
    assign bus.flush_busy = (state != S_IDLE);
    assign bus.flush_done = (state == S_DONE);
endmodule
